// File: rtl/com_packet_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : com_packet_encoder_pkg
// Description : Shared opcode, packet and field-position definitions for the
//               command-packet link (encoder and decoder side).
// Revision    : 1.0 - initial release
// ============================================================================
package com_packet_encoder_pkg;

    localparam int COM_PACKET_W = 16;

    localparam int ITER_LSB = 10;
    localparam int ITER_MSB = 13;
    localparam int NUM_FV_W = 5;
    localparam int WB_W     = 4;

    typedef enum logic [1:0] {
        TASK   = 2'd0,
        REPLAY = 2'd1,
        STREAM = 2'd2,
        WB     = 2'd3
    } com_op_e;

    typedef struct packed {
        logic                    valid;
        logic [COM_PACKET_W-1:0] packet;
    } com_packet_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/com_packet_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : com_packet_encoder_if
// Description : Host command port plus the encoder-to-decoder packet link.
//               master = encoder side, slave = host/decoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface com_packet_encoder_if
    import com_packet_encoder_pkg::*;
#(
    parameter int PACKET_W = COM_PACKET_W
);
    logic                         host_valid;
    logic                         host_ready;
    logic [1:0]                   host_op;
    logic [ITER_MSB-ITER_LSB:0]   host_iter_mask;
    logic [PACKET_W-7:0]          host_payload;
    logic                         com_valid;
    logic [PACKET_W-1:0]          com_packet;
    logic                         fifo_stall;
    logic                         task_complete;

    modport master (
        input  host_valid, host_op, host_iter_mask, host_payload,
        output host_ready,
        output com_valid, com_packet,
        input  fifo_stall, task_complete
    );

    modport slave (
        output host_valid, host_op, host_iter_mask, host_payload,
        input  host_ready,
        input  com_valid, com_packet,
        output fifo_stall, task_complete
    );
endinterface
`default_nettype wire

// File: rtl/com_packet_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : com_packet_encoder_fifo
// Description : Synchronous FIFO (com_fifo) holding pre-encoded packets;
//               first-word fall-through read of the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module com_packet_encoder_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    input  wire logic [WIDTH-1:0]           wdata_i,
    output logic      [WIDTH-1:0]           rdata_o,
    output logic      [$clog2(DEPTH):0]     count_o,
    output logic                            full_o,
    output logic                            empty_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/com_packet_encoder.sv
`default_nettype none
// ============================================================================
// Module      : com_packet_encoder
// Description : Buffers host commands, encodes them into 2-bit-opcode packets
//               and issues them to the decoder under fifo_stall backpressure.
//               Optional per-opcode counters: define COM_ENC_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module com_packet_encoder
    import com_packet_encoder_pkg::*;
#(
    parameter int PACKET_W   = 16,
    parameter int DEPTH      = 8,
    parameter int MAX_REPLAY = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    com_packet_encoder_if.master        bus,
    output logic                        prog_done,
    output logic [1:0]                  replay_cnt,
    output logic [$clog2(DEPTH):0]      fifo_count
`ifdef COM_ENC_STATS_EN
    ,
    output logic [15:0]                 stat_task,
    output logic [15:0]                 stat_replay,
    output logic [15:0]                 stat_stream,
    output logic [15:0]                 stat_wb
`endif
);
    localparam int         PAYLOAD_W   = PACKET_W - 6;
    localparam logic [1:0] REPLAY_LAST = 2'(MAX_REPLAY - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_HOLD      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    state_e                state_q;
    logic                  com_valid_q;
    logic [PACKET_W-1:0]   com_packet_q;
    logic                  prog_done_q;
    logic [1:0]            replay_cnt_q;

    logic [PACKET_W-1:0]   w_enc;
    logic [PACKET_W-1:0]   w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_load;
    logic                  w_final_replay;
    com_op_e               w_issued_op;

    // Packet formatting happens at push time so the FIFO holds final packets.
    always_comb begin
        w_enc = '0;
        w_enc[PACKET_W-1 -: 2] = bus.host_op;
        case (com_op_e'(bus.host_op))
            TASK: begin
                w_enc[ITER_MSB:ITER_LSB]  = bus.host_iter_mask;
                w_enc[PAYLOAD_W-1:0]      = bus.host_payload;
            end
            REPLAY: w_enc[PAYLOAD_W-1:0] = bus.host_payload;
            STREAM: w_enc[NUM_FV_W-1:0]  = bus.host_payload[NUM_FV_W-1:0];
            WB:     w_enc[WB_W-1:0]      = bus.host_payload[WB_W-1:0];
            default: w_enc = '0;
        endcase
    end

    assign w_push = bus.host_valid && bus.host_ready;

    com_packet_encoder_fifo #(
        .WIDTH (PACKET_W),
        .DEPTH (DEPTH)
    ) u_com_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_load),
        .wdata_i (w_enc),
        .rdata_o (w_head),
        .count_o (fifo_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_issued_op    = com_op_e'(com_packet_q[PACKET_W-1 -: 2]);
    assign w_final_replay = (w_issued_op == REPLAY) && (replay_cnt_q == REPLAY_LAST);

    // Pop and output-register load are the same event; stall only gates it.
    always_comb begin
        w_load = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: w_load = !w_empty && !bus.fifo_stall;
            S_ISSUE:        w_load = !w_empty && !bus.fifo_stall && !w_final_replay;
            default:        w_load = 1'b0;
        endcase
    end

`ifdef COM_ENC_STATS_EN
    logic [15:0] stat_q [4];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            com_valid_q  <= 1'b0;
            com_packet_q <= '0;
            prog_done_q  <= 1'b0;
            replay_cnt_q <= '0;
`ifdef COM_ENC_STATS_EN
            for (int i = 0; i < 4; i++) begin
                stat_q[i] <= '0;
            end
`endif
        end else begin
            prog_done_q <= 1'b0;
            com_valid_q <= w_load;
            if (w_load) begin
                com_packet_q <= w_head;
            end
`ifdef COM_ENC_STATS_EN
            if (w_load) begin
                stat_q[w_head[PACKET_W-1 -: 2]] <= sat_inc16(stat_q[w_head[PACKET_W-1 -: 2]]);
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (w_load) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Replay iteration index is the count before this packet.
                    if (w_issued_op == REPLAY && replay_cnt_q != REPLAY_LAST) begin
                        replay_cnt_q <= replay_cnt_q + 2'd1;
                    end
                    if (w_final_replay) begin
                        state_q <= S_WAIT_DONE;
                    end else if (w_load) begin
                        state_q <= S_ISSUE;
                    end else if (bus.fifo_stall) begin
                        state_q <= S_HOLD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!bus.fifo_stall) begin
                        state_q <= w_load ? S_ISSUE : S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.task_complete) begin
                        prog_done_q  <= 1'b1;
                        replay_cnt_q <= '0;
                        state_q      <= S_IDLE;
`ifdef COM_ENC_STATS_EN
                        for (int i = 0; i < 4; i++) begin
                            stat_q[i] <= '0;
                        end
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.host_ready = !w_full;
    assign bus.com_valid  = com_valid_q;
    assign bus.com_packet = com_packet_q;
    assign prog_done      = prog_done_q;
    assign replay_cnt     = replay_cnt_q;

`ifdef COM_ENC_STATS_EN
    assign stat_task   = stat_q[0];
    assign stat_replay = stat_q[1];
    assign stat_stream = stat_q[2];
    assign stat_wb     = stat_q[3];
`endif
endmodule
`default_nettype wire

// File: tb/tb_com_packet_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_packet_encoder
// Description : Directed self-checking bench for com_packet_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_com_packet_encoder;

    logic       clk;
    logic       reset;
    logic       prog_done;
    logic [1:0] replay_cnt;
    logic [3:0] fifo_count;
`ifdef COM_ENC_STATS_EN
    logic [15:0] stat_task, stat_replay, stat_stream, stat_wb;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    com_packet_encoder_if #(.PACKET_W(16)) bus ();

    com_packet_encoder #(
        .PACKET_W   (16),
        .DEPTH      (8),
        .MAX_REPLAY (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .prog_done  (prog_done),
        .replay_cnt (replay_cnt),
        .fifo_count (fifo_count)
`ifdef COM_ENC_STATS_EN
        ,
        .stat_task   (stat_task),
        .stat_replay (stat_replay),
        .stat_stream (stat_stream),
        .stat_wb     (stat_wb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] mask, input logic [9:0] payload);
        bus.host_valid     = 1'b1;
        bus.host_op        = op;
        bus.host_iter_mask = mask;
        bus.host_payload   = payload;
        tick();
        bus.host_valid     = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.host_valid     = 1'b0;
        bus.host_op        = 2'b00;
        bus.host_iter_mask = 4'b0;
        bus.host_payload   = 10'b0;
        bus.fifo_stall     = 1'b0;
        bus.task_complete  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check_eq("rst_ready",  32'(bus.host_ready), 32'd1);
        check_eq("rst_valid",  32'(bus.com_valid),  32'd0);
        check_eq("rst_packet", 32'(bus.com_packet), 32'h0);
        check_eq("rst_done",   32'(prog_done),      32'd0);
        check_eq("rst_replay", 32'(replay_cnt),     32'd0);
        check_eq("rst_count",  32'(fifo_count),     32'd0);

        // Single task packet: latency of two edges from the push
        push(2'b00, 4'b0011, 10'h155);
        check_eq("t1_count1", 32'(fifo_count),    32'd1);
        check_eq("t1_valid0", 32'(bus.com_valid), 32'd0);
        tick();
        check_eq("t1_valid1", 32'(bus.com_valid),  32'd1);
        check_eq("t1_packet", 32'(bus.com_packet), 32'h0D55);
        check_eq("t1_count0", 32'(fifo_count),     32'd0);
        tick();
        check_eq("t1_valid2", 32'(bus.com_valid), 32'd0);

        // Three back-to-back packets
        push(2'b10, 4'b0000, 10'd16);
        check_eq("t2_v0", 32'(bus.com_valid), 32'd0);
        push(2'b11, 4'b0000, 10'd9);
        check_eq("t2_v1", 32'(bus.com_valid),  32'd1);
        check_eq("t2_p1", 32'(bus.com_packet), 32'h8010);
        push(2'b00, 4'b1010, 10'h3FF);
        check_eq("t2_v2", 32'(bus.com_valid),  32'd1);
        check_eq("t2_p2", 32'(bus.com_packet), 32'hC009);
        tick();
        check_eq("t2_v3", 32'(bus.com_valid),  32'd1);
        check_eq("t2_p3", 32'(bus.com_packet), 32'h2BFF);
        tick();
        check_eq("t2_v4", 32'(bus.com_valid), 32'd0);

        // Stall for 5 cycles starting in the issue cycle of the first packet
        push(2'b11, 4'b0000, 10'd1);
        push(2'b11, 4'b0000, 10'd2);
        check_eq("t3_v1", 32'(bus.com_valid),  32'd1);
        check_eq("t3_p1", 32'(bus.com_packet), 32'hC001);
        bus.fifo_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t3_hold", 32'(bus.com_valid), 32'd0);
        end
        tick();
        bus.fifo_stall = 1'b0;
        check_eq("t3_hold5", 32'(bus.com_valid), 32'd0);
        tick();
        check_eq("t3_v2", 32'(bus.com_valid),  32'd1);
        check_eq("t3_p2", 32'(bus.com_packet), 32'hC002);
        tick();
        check_eq("t3_v3", 32'(bus.com_valid), 32'd0);

        // task_complete outside WAIT_DONE is ignored
        bus.task_complete = 1'b1;
        tick();
        bus.task_complete = 1'b0;
        check_eq("t4_ign_done", 32'(prog_done), 32'd0);

        // Four replays then a task held until task_complete
        push(2'b01, 4'b0000, 10'h001);
        push(2'b01, 4'b0000, 10'h002);
        check_eq("t4_p1",  32'(bus.com_packet), 32'h4001);
        check_eq("t4_rc0", 32'(replay_cnt),     32'd0);
        push(2'b01, 4'b0000, 10'h003);
        check_eq("t4_rc1", 32'(replay_cnt), 32'd1);
        push(2'b01, 4'b0000, 10'h004);
        check_eq("t4_rc2", 32'(replay_cnt), 32'd2);
        push(2'b00, 4'b0000, 10'h02A);
        check_eq("t4_rc3", 32'(replay_cnt),     32'd3);
        check_eq("t4_p4",  32'(bus.com_packet), 32'h4004);
        check_eq("t4_v4",  32'(bus.com_valid),  32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t4_wait_v", 32'(bus.com_valid), 32'd0);
        end
        check_eq("t4_wait_rc",  32'(replay_cnt), 32'd3);
        check_eq("t4_wait_cnt", 32'(fifo_count), 32'd1);
        bus.task_complete = 1'b1;
        tick();
        bus.task_complete = 1'b0;
        check_eq("t4_done",    32'(prog_done),     32'd1);
        check_eq("t4_rc_clr",  32'(replay_cnt),    32'd0);
        check_eq("t4_done_v",  32'(bus.com_valid), 32'd0);
        tick();
        check_eq("t4_done_pulse", 32'(prog_done),      32'd0);
        check_eq("t4_task_v",     32'(bus.com_valid),  32'd1);
        check_eq("t4_task_p",     32'(bus.com_packet), 32'h002A);
        tick();

        // Fill under stall; ninth push dropped
        bus.fifo_stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(2'b11, 4'b0000, 10'(k));
            check_eq("t5_fill_cnt", 32'(fifo_count), 32'(k + 1));
        end
        check_eq("t5_ready0", 32'(bus.host_ready), 32'd0);
        push(2'b11, 4'b0000, 10'hF);
        check_eq("t5_drop_cnt", 32'(fifo_count), 32'd8);
        check_eq("t5_stall_v",  32'(bus.com_valid), 32'd0);

        // Drain three, stall into HOLD, then reset with 5 queued
        bus.fifo_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t6_drain_v", 32'(bus.com_valid),  32'd1);
            check_eq("t6_drain_p", 32'(bus.com_packet), 32'hC000 | 32'(k));
        end
        bus.fifo_stall = 1'b1;
        tick();
        tick();
        check_eq("t6_hold_v",   32'(bus.com_valid), 32'd0);
        check_eq("t6_hold_cnt", 32'(fifo_count),    32'd5);
        reset          = 1'b1;
        bus.fifo_stall = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("t6_rst_cnt",   32'(fifo_count),     32'd0);
        check_eq("t6_rst_v",     32'(bus.com_valid),  32'd0);
        check_eq("t6_rst_p",     32'(bus.com_packet), 32'h0);
        check_eq("t6_rst_ready", 32'(bus.host_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_post_v",   32'(bus.com_valid), 32'd0);
            check_eq("t6_post_cnt", 32'(fifo_count),    32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/com_packet_encoder.md
Name: com_packet_encoder

Overview:
- Transmit end of the command-packet interface that feeds the dataflow decoder.
- Accepts high-level commands from the host/controller side and buffers them in an 8-entry FIFO.
- Encodes each command into the 2-bit-opcode packet format and issues it one per cycle, honouring the decoder's fifo_stall backpressure.
- Tracks replay-iteration commands and task completion, so the host knows when the full program has retired.

Parameters:
- PACKET_W, 16, packet width; opcode in [PACKET_W-1:PACKET_W-2].
- DEPTH, 8, command FIFO entries; power of two.
- MAX_REPLAY, 4, replay iterations per program; the final replay is iteration MAX_REPLAY-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- host_valid  in  1  command offered
- host_ready  out  1  FIFO can accept (not full)
- host_op  in  2  00 task, 01 replay, 10 stream-begin, 11 weights-boundary
- host_iter_mask  in  4  task iteration-enable mask, op 00 only
- host_payload  in  PACKET_W-6  task body / replay body / Num_FV[4:0] / boundary[3:0]
- com_valid  out  1  packet valid to decoder
- com_packet  out  PACKET_W  encoded packet
- fifo_stall  in  1  decoder backpressure
- task_complete  in  1  decoder pulse: final replay retired
- prog_done  out  1  one-cycle pulse on task_complete
- replay_cnt  out  2  replay packets issued since reset/prog_done
- fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset values: host_ready=1, com_valid=0, com_packet=0, prog_done=0, replay_cnt=0, fifo_count=0. FIFO pointers are cleared; reset mid-operation discards all queued and in-flight packets.
- Write: host_valid && host_ready pushes one entry next edge. The entry stores the encoded packet, built at push time:
  - op 00: {2'b00, iter_mask, payload[PACKET_W-7:0]}
  - op 01: {2'b01, 4'b0, payload}
  - op 10: {2'b10, zero-fill, payload[4:0]}
  - op 11: {2'b11, zero-fill, payload[3:0]}
- host_ready = (fifo_count != DEPTH). A push while full is ignored.
- Handshake rule: a packet presented with com_valid=1 is consumed in that cycle, whatever fifo_stall is.
- Issue rule: fifo_stall=1 forbids presenting the next packet; the output register loads only in a cycle where fifo_stall=0.
- Output is registered, so there is 1 cycle of latency from FIFO head to com_valid.
- Simultaneous push and pop are both performed; count is unchanged.
- Pushing into an empty FIFO gives com_valid at the earliest 2 edges after the push.
- State machine:
  - IDLE: FIFO empty; com_valid=0. Go to ISSUE when count>0 and !fifo_stall.
  - ISSUE: present the head packet for 1 cycle and pop it.
    - If the next head exists and fifo_stall=0, stay in ISSUE (back-to-back).
    - If fifo_stall=1, go to HOLD.
    - If the issued packet is op 01 with replay_cnt==MAX_REPLAY-1, go to WAIT_DONE.
    - Otherwise go to IDLE.
  - HOLD: com_valid=0. Go to ISSUE or IDLE when fifo_stall=0.
  - WAIT_DONE: com_valid=0 and no issue. On task_complete, pulse prog_done, clear replay_cnt, go to IDLE.
- replay_cnt increments on each issued op 01 and saturates at MAX_REPLAY-1.
- task_complete outside WAIT_DONE is ignored.
- fifo_stall is combinational from the decoder; the block must not create a comb path from fifo_stall to com_valid.

Optional Feature:
- Macro COM_ENC_STATS_EN.
- With it: adds output ports stat_task, stat_replay, stat_stream, stat_wb (16 bits each). Each counts issued packets per opcode, saturates at 16'hFFFF, and is cleared by reset and by prog_done.
- Without it: the ports and counters do not exist; everything else is identical.

Decomposition:
- Shared package holds:
  - opcode enum com_op_e (TASK=0, REPLAY=1, STREAM=2, WB=3)
  - the com_packet struct {valid, packet}, used by both encoder and decoder
  - field-position constants: ITER_LSB=10, ITER_MSB=13, NUM_FV_W=5, WB_W=4
- One natural sub-module: com_fifo, a synchronous FIFO with push, pop, count, full and empty flags. The encoder FSM and the packet formatter stay in the top level.

Test Plan:
- Push op00 mask=4'b0011, payload=10'h155 with the FIFO empty, fifo_stall=0 -> com_valid at the 2nd edge after the push, com_packet=16'h0D55; count returns to 0.
- Push 3 packets (op10 payload 5'd16, op11 payload 4'd9, op00), no stall -> three consecutive valid cycles with 16'h8010, 16'hC009, then the task packet.
- Push 2 packets, hold fifo_stall=1 for 5 cycles after the first is issued -> first packet issued exactly once; com_valid=0 for 5 cycles; second issued the cycle after stall drops.
- Issue 4 op01 packets -> replay_cnt goes 1,2,3 and state enters WAIT_DONE. A queued op00 is held until task_complete; then prog_done pulses 1 cycle and replay_cnt=0.
- Fill the FIFO with 8 pushes under stall -> host_ready=0; a 9th push is dropped; count=8.
- Assert reset mid-HOLD with 5 entries queued -> next cycle count=0, com_valid=0, state IDLE; no queued packet is ever issued.
